kb_rx_fifo: RTL and testbench
=============================

Name: kb_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-register scan block.
- Samples kb_clk_i/kb_dat_i with synchroniser, glitch filter and an inter-bit timeout, then checks each 11-bit frame.
- Optionally folds E0/F0 prefixes into per-key flags.
- Queues decoded codes in a first-word-fall-through FIFO read by the bus-side keyboard controller, so no scan codes are lost between CPU polls.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, minimum 2.
- FILTER_LEN, 4: consecutive equal samples required before the filtered kb_clk changes; minimum 1.
- TIMEOUT, 50000: clk_i cycles without a falling edge mid-frame before the frame is abandoned.
- DECODE_PREFIX, 1: 1 = absorb E0/F0 into ext_o/brk_o; 0 = push every byte raw.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- kb_clk_i  in  1  PS/2 clock (asynchronous)
- kb_dat_i  in  1  PS/2 data (asynchronous)
- rd_i  in  1  pop FIFO head; honoured only when valid_o=1
- clr_i  in  1  clear overflow_o
- valid_o  out  1  FIFO not empty
- code_o  out  8  head scan code
- ext_o  out  1  head had E0 prefix
- brk_o  out  1  head had F0 prefix (key release)
- count_o  out  $clog2(DEPTH)+1  entries held
- full_o  out  1  count_o==DEPTH
- overflow_o  out  1  sticky; a push was dropped
- frame_err_o  out  1  one-cycle pulse on a bad or abandoned frame

Behaviour:
- Reset (rst_i=0, async): all state cleared. Outputs valid_o=0, code_o=0, ext_o=0, brk_o=0, count_o=0, full_o=0, overflow_o=0, frame_err_o=0. Filtered kb_clk resets to 1. A frame in progress is discarded.
- Input path:
  - 2-FF synchroniser on each input.
  - Filtered clk toggles after FILTER_LEN consecutive samples differ from its current value.
  - Falling edge = filtered clk 1->0.
  - Data is sampled from the synchronised kb_dat on that same cycle.
- Frame receiver states: IDLE, SHIFT, CHECK.
  - IDLE: first falling edge captures bit0 -> SHIFT, bitcnt=1.
  - SHIFT: each falling edge stores bit[bitcnt] and increments bitcnt. The edge capturing bit 10 -> CHECK.
  - CHECK (one cycle): frame is valid iff bit0==0, bit10==1 and ^bit[9:1]==1 (odd parity). Valid -> byte=bit[8:1] to the decoder. Invalid -> frame_err_o=1. Then -> IDLE.
  - Timeout: in SHIFT, a cycle counter reset on each falling edge. Reaching TIMEOUT -> frame_err_o=1, return to IDLE. The counter is idle (held 0) in IDLE.
- Decoder:
  - DECODE_PREFIX=1:
    - 0xE0 sets ext_pend; 0xF0 sets brk_pend. No push for either.
    - Any other byte pushes {ext_pend, brk_pend, byte}, then clears both pending flags.
    - frame_err also clears both pending flags.
  - DECODE_PREFIX=0: every valid byte is pushed with ext=brk=0.
- Latency: push occurs in the cycle after CHECK; valid_o is high the cycle after that.
- FIFO: 10-bit entries. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Outputs are driven from the head combinationally (FWFT).
  - Pop when rd_i && valid_o. rd_i while empty is ignored.
  - Push when full without a simultaneous pop: entry dropped, overflow_o<=1, FIFO contents unchanged.
  - Push when full with a simultaneous pop: both happen; count unchanged.
  - Push when empty with a simultaneous rd_i: push only, because valid_o was 0.
  - overflow_o is cleared by clr_i. If clr_i and a new overflow coincide, set wins.
- code_o/ext_o/brk_o are 0 when empty.

Decomposition:
- Shared package kb_pkg holds:
  - constants KB_PREFIX_EXT=8'hE0, KB_PREFIX_BRK=8'hF0, KB_FRAME_BITS=11;
  - entry typedef {ext, brk, code[7:0]};
  - receiver state enum.
- One sub-module, kb_frame_rx: synchroniser, filter, timeout and frame check. It outputs byte_o, byte_vld_o and err_o.
- Decoder and FIFO stay in the top module.

Test Plan:
1. Single key press: frame for 0x1C (start 0, data LSB-first, parity 0, stop 1), kb_clk period 80 us -> entry code 0x1C, ext=0, brk=0. valid_o=1 exactly two cycles after the stop-bit falling edge.
2. Prefixes: bytes E0, F0, 75 -> one entry code 0x75, ext=1, brk=1, count_o=1. With DECODE_PREFIX=0 -> three entries E0, F0, 75 with flags 0.
3. Bad frame: 0x1C sent with parity 1, then a frame with stop bit 0 -> frame_err_o pulses twice, count_o stays 0. A following E0 plus a corrupted frame plus 0x1C -> ext=0 on the 0x1C entry.
4. Timeout: send 5 bits then hold kb_clk high -> frame_err_o pulses TIMEOUT cycles after the last edge. The next full frame 0x29 is received correctly.
5. Overflow: DEPTH=4, push 5 codes 01..05 with no reads -> full_o=1, overflow_o=1, reads return 01..04. clr_i clears overflow_o. A push coinciding with a pop while full -> count_o stays 4, no overflow.
6. Glitch and reset: 1-cycle low glitches on kb_clk_i (shorter than FILTER_LEN) -> no bits captured. Asserting rst_i low mid-frame -> all outputs 0 immediately; the next frame decodes correctly.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: prefix bytes,
// frame length, FIFO entry layout and receiver state encoding.
package kb_pkg;

   localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
   localparam int         KB_FRAME_BITS = 11;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kb_entry_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_CHECK = 2'd2
   } kb_rx_state_e;

endpackage

// File: rtl/kb_frame_rx.sv
// PS/2 frame receiver: synchronises and de-glitches the keyboard lines,
// shifts an 11-bit frame on filtered falling edges and validates it.
module kb_frame_rx
   import kb_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       kb_clk_i,
   input  logic       kb_dat_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       err_o
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]               clk_sync;
   logic [1:0]               dat_sync;
   logic                     filt_clk;
   logic [FW-1:0]            filt_cnt;
   logic                     differ;
   logic                     fall;
   kb_rx_state_e             state_q, state_d;
   logic [KB_FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]               bitcnt_q, bitcnt_d;
   logic [TW-1:0]            tcnt_q, tcnt_d;
   logic                     frame_ok;
   logic                     byte_vld_d, err_d;

   // Synchronisers reset to the idle-high line level so reset release
   // never looks like a falling edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], kb_clk_i};
         dat_sync <= {dat_sync[0], kb_dat_i};
      end
   end

   assign differ = (clk_sync[1] != filt_clk);
   assign fall   = filt_clk && differ && (filt_cnt == FW'(FILTER_LEN - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (!differ) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
         filt_clk <= ~filt_clk;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign frame_ok = !shreg_q[0] && shreg_q[KB_FRAME_BITS-1] && (^shreg_q[9:1]);

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bitcnt_d   = bitcnt_q;
      tcnt_d     = '0;
      byte_vld_d = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (fall) begin
               shreg_d[0] = dat_sync[1];
               bitcnt_d   = 4'd1;
               state_d    = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (fall) begin
               shreg_d[bitcnt_q] = dat_sync[1];
               bitcnt_d          = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'(KB_FRAME_BITS - 1)) state_d = RX_CHECK;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = RX_IDLE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         RX_CHECK: begin
            state_d    = RX_IDLE;
            byte_vld_d = frame_ok;
            err_d      = !frame_ok;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= RX_IDLE;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         tcnt_q     <= '0;
         byte_vld_o <= 1'b0;
         err_o      <= 1'b0;
         byte_o     <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
         tcnt_q     <= tcnt_d;
         byte_vld_o <= byte_vld_d;
         err_o      <= err_d;
         if (byte_vld_d) byte_o <= shreg_q[8:1];
      end
   end

endmodule

// File: rtl/kb_rx_fifo.sv
// PS/2 keyboard receiver with optional E0/F0 prefix folding and a
// first-word-fall-through queue of decoded scan codes.
module kb_rx_fifo
   import kb_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int FILTER_LEN    = 4,
   parameter int TIMEOUT       = 50000,
   parameter int DECODE_PREFIX = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   kb_clk_i,
   input  logic                   kb_dat_i,
   input  logic                   rd_i,
   input  logic                   clr_i,
   output logic                   valid_o,
   output logic [7:0]             code_o,
   output logic                   ext_o,
   output logic                   brk_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   overflow_o,
   output logic                   frame_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]  rx_byte;
   logic        rx_vld;
   logic        rx_err;
   logic        ext_pend, brk_pend;
   logic        push, pop, wr;
   kb_entry_t   push_ent;
   kb_entry_t   head;
   kb_entry_t   mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;

   kb_frame_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_frame_rx (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .kb_clk_i   (kb_clk_i),
      .kb_dat_i   (kb_dat_i),
      .byte_o     (rx_byte),
      .byte_vld_o (rx_vld),
      .err_o      (rx_err)
   );

   always_comb begin
      push     = 1'b0;
      push_ent = '0;
      if (rx_vld) begin
         if (DECODE_PREFIX != 0) begin
            push     = (rx_byte != KB_PREFIX_EXT) && (rx_byte != KB_PREFIX_BRK);
            push_ent = '{ext: ext_pend, brk: brk_pend, code: rx_byte};
         end else begin
            push     = 1'b1;
            push_ent = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
         end
      end
   end

   // A broken frame may have swallowed the byte the prefix belonged to,
   // so pending prefixes do not survive an error.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (rx_err) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (rx_vld && (DECODE_PREFIX != 0)) begin
         if (rx_byte == KB_PREFIX_EXT) begin
            ext_pend <= 1'b1;
         end else if (rx_byte == KB_PREFIX_BRK) begin
            brk_pend <= 1'b1;
         end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   assign valid_o = (count != '0);
   assign full_o  = (count == CW'(DEPTH));
   assign pop     = rd_i && valid_o;
   assign wr      = push && (!full_o || pop);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (wr) begin
            mem[wptr] <= push_ent;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         count <= count + CW'(wr) - CW'(pop);
         if (push && full_o && !pop) overflow_o <= 1'b1;
         else if (clr_i)             overflow_o <= 1'b0;
      end
   end

   assign head        = mem[rptr];
   assign code_o      = valid_o ? head.code : 8'h00;
   assign ext_o       = valid_o && head.ext;
   assign brk_o       = valid_o && head.brk;
   assign count_o     = count;
   assign frame_err_o = rx_err;

endmodule

// File: tb/tb_kb_rx_fifo.sv
// Randomised and directed bench for kb_rx_fifo against a queue-based model;
// a prefix-folding DUT and a raw DUT share the same keyboard lines.
module tb_kb_rx_fifo;

   localparam int FL   = 4;
   localparam int TO   = 200;
   localparam int HALF = 12;
   localparam int DM   = 4;
   localparam int DR   = 16;

   logic clk = 1'b0;
   logic rst_n, kb_clk, kb_dat, rd, clr, rd2, clr2;
   logic valid, ext, brk, full, ovf, ferr;
   logic valid2, ext2, brk2, full2, ovf2, ferr2;
   logic [7:0] code, code2;
   logic [2:0] count;
   logic [4:0] count2;

   int n_chk = 0, n_fail = 0;
   int exp_err = 0, err_seen = 0, err2_seen = 0;
   logic [9:0] q_main[$];
   logic [9:0] q_raw[$];
   bit m_ext, m_brk, m_ovf;

   always #5 clk = ~clk;

   kb_rx_fifo #(.DEPTH(DM), .FILTER_LEN(FL), .TIMEOUT(TO), .DECODE_PREFIX(1)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat),
      .rd_i(rd), .clr_i(clr), .valid_o(valid), .code_o(code), .ext_o(ext),
      .brk_o(brk), .count_o(count), .full_o(full), .overflow_o(ovf),
      .frame_err_o(ferr));

   kb_rx_fifo #(.DEPTH(DR), .FILTER_LEN(FL), .TIMEOUT(TO), .DECODE_PREFIX(0)) u_raw (
      .clk_i(clk), .rst_i(rst_n), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat),
      .rd_i(rd2), .clr_i(clr2), .valid_o(valid2), .code_o(code2), .ext_o(ext2),
      .brk_o(brk2), .count_o(count2), .full_o(full2), .overflow_o(ovf2),
      .frame_err_o(ferr2));

   always @(negedge clk) begin
      if (ferr)  err_seen++;
      if (ferr2) err2_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference decode of one received frame (after any same-cycle pop).
   task automatic model_frame(input logic [7:0] b, input bit ok);
      if (!ok) begin
         exp_err++;
         m_ext = 0;
         m_brk = 0;
         return;
      end
      if (q_raw.size() < DR) q_raw.push_back({2'b00, b});
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (q_main.size() < DM) q_main.push_back({m_ext, m_brk, b});
         else m_ovf = 1;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic send_bit(input logic d);
      @(negedge clk) kb_dat = d;
      repeat (HALF) @(negedge clk);
      kb_clk = 0;
      repeat (HALF) @(negedge clk);
      kb_clk = 1;
   endtask

   // Filtered edge lands FL+2 clocks after the pin edge; valid_o follows two later.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit pop, input bit lat);
      logic [10:0] f;
      f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(f[i]);
      @(negedge clk) kb_dat = f[10];
      repeat (HALF) @(negedge clk);
      kb_clk = 0;
      for (int k = 1; k <= HALF; k++) begin
         @(negedge clk);
         if (k == FL + 3) begin
            if (lat) chk("lat_pre", valid, 0);
            if (pop) begin
               rd = 1;
               if (q_main.size() > 0) begin
                  chk("pop_head", {ext, brk, code}, q_main[0]);
                  void'(q_main.pop_front());
               end
            end
         end
         if (k == FL + 4) begin
            rd = 0;
            if (lat) chk("lat_post", valid, 1);
         end
      end
      kb_clk = 1;
      model_frame(b, !bad_par && !bad_stop);
      repeat (8) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cnt"}, count, q_main.size());
      chk({tag, "_ovf"}, ovf, m_ovf);
      chk({tag, "_full"}, full, q_main.size() == DM);
      chk({tag, "_head"}, {valid, ext, brk, code},
          q_main.size() > 0 ? {1'b1, q_main[0]} : 11'h0);
      chk({tag, "_err"}, err_seen, exp_err);
      chk({tag, "_rawcnt"}, count2, q_raw.size());
      chk({tag, "_rawerr"}, err2_seen, exp_err);
   endtask

   task automatic pop_main(input int n);
      for (int i = 0; i < n; i++) begin
         chk("rd_head", {ext, brk, code}, q_main[0]);
         rd = 1;
         void'(q_main.pop_front());
         @(negedge clk);
      end
      rd = 0;
      chk("rd_cnt", count, q_main.size());
   endtask

   task automatic drain_all();
      pop_main(q_main.size());
      rd = 1;
      @(negedge clk);
      rd = 0;
      chk("empty_rd", {valid, count}, 4'h0);
      while (q_raw.size() > 0) begin
         chk("raw_head", {ext2, brk2, code2}, q_raw[0]);
         rd2 = 1;
         void'(q_raw.pop_front());
         @(negedge clk);
      end
      rd2 = 0;
      chk("raw_empty", {valid2, count2}, 6'h0);
   endtask

   initial begin
      int tpos;
      logic [10:0] f;
      logic [7:0] b;
      rst_n = 0; kb_clk = 1; kb_dat = 1; rd = 0; clr = 0; rd2 = 0; clr2 = 0;
      repeat (3) @(negedge clk);
      chk("rst_out", {valid, code, ext, brk, count, full, ovf, ferr}, 16'h0);
      rst_n = 1;
      repeat (4) @(negedge clk);

      // single key, with exact push latency
      send_frame(8'h1C, 0, 0, 0, 1);
      check_state("t1");
      drain_all();

      // prefix folding vs raw
      send_frame(8'hE0, 0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 0, 0);
      check_state("t2");
      chk("t2_ent", {ext, brk, code}, 10'h375);
      drain_all();

      // bad parity, bad stop, then a broken frame between E0 and 1C
      send_frame(8'h1C, 1, 0, 0, 0);
      send_frame(8'h1C, 0, 1, 0, 0);
      check_state("t3a");
      send_frame(8'hE0, 0, 0, 0, 0);
      send_frame(8'h44, 1, 0, 0, 0);
      send_frame(8'h1C, 0, 0, 0, 0);
      check_state("t3b");
      drain_all();

      // mid-frame timeout
      f = {1'b1, ~(^8'h29), 8'h29, 1'b0};
      for (int i = 0; i < 4; i++) send_bit(f[i]);
      @(negedge clk) kb_dat = f[4];
      repeat (HALF) @(negedge clk);
      kb_clk = 0;
      tpos = -1;
      for (int k = 1; k <= TO + 40; k++) begin
         @(negedge clk);
         if (k == HALF) kb_clk = 1;
         if (ferr && tpos < 0) tpos = k;
      end
      chk("to_lat", tpos, FL + 2 + TO);
      exp_err++; m_ext = 0; m_brk = 0;
      send_frame(8'h29, 0, 0, 0, 0);
      check_state("t4");
      drain_all();

      // overflow, clear, push+pop while full
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0, 0);
      check_state("t5a");
      chk("t5_flags", {full, ovf}, 2'b11);
      @(negedge clk) clr = 1;
      @(negedge clk) clr = 0;
      m_ovf = 0;
      check_state("t5b");
      send_frame(8'h06, 0, 0, 1, 0);
      check_state("t5c");
      drain_all();

      // randomised traffic
      for (int n = 0; n < 28; n++) begin
         case ($urandom_range(0, 7))
            0, 1:    b = 8'hE0;
            2:       b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         send_frame(b, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 2) == 0, 0);
         check_state("rnd");
         pop_main($urandom_range(0, q_main.size()));
         if (q_raw.size() > 8) drain_all();
      end
      drain_all();

      // short glitches must not clock in bits
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) kb_clk = 0;
         @(negedge clk) kb_clk = 1;
         repeat (6) @(negedge clk);
      end
      check_state("t6a");
      send_frame(8'h1C, 0, 0, 0, 0);
      check_state("t6b");

      // async reset mid-frame with data queued
      f = {1'b1, ~(^8'h5A), 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) send_bit(f[i]);
      @(negedge clk) rst_n = 0;
      #1;
      chk("rst_mid", {valid, code, ext, brk, count, full, ovf, ferr}, 16'h0);
      chk("rst_mid_raw", {valid2, count2}, 6'h0);
      q_main.delete(); q_raw.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (4) @(negedge clk);
      send_frame(8'h5A, 0, 0, 0, 0);
      check_state("t6c");
      drain_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
